// File: rtl/exec_unit_cdb.sv
// rtl/exec_unit_cdb.sv - single functional unit that computes one instruction and holds its result for the CDB
//
// Optional feature macro: RVCPU_EXU_MUL_EN
//   defined   : opcode 2'b10 is a multi-cycle MUL (EXEC state and countdown present)
//   undefined : opcode 2'b10 is a single-cycle XOR, MUL_CYCLES is unused
//
// Ports:
//   clk, RST          clock, synchronous active-high reset
//   InEn              reservation station presents a ready entry
//   opIn              2-bit opcode (ADD, SUB, MUL/XOR, SLT)
//   dataIn1, dataIn2  operands j and k
//   labelIn           RS label of the presented entry
//   EXEable           unit can accept this cycle (combinational)
//   cdbReq            held result is valid and requesting the CDB
//   cdbGrant          arbiter grant for the held result
//   cdbLabel, cdbData label and value of the held result

module exec_unit_cdb #(
    parameter int MUL_CYCLES = 4
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        InEn,
    input  logic [1:0]  opIn,
    input  logic [31:0] dataIn1,
    input  logic [31:0] dataIn2,
    input  logic [3:0]  labelIn,
    output logic        EXEable,
    output logic        cdbReq,
    input  logic        cdbGrant,
    output logic [3:0]  cdbLabel,
    output logic [31:0] cdbData
);

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_SLT = 2'b11;

`ifdef RVCPU_EXU_MUL_EN
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd1, EXEC = 2'd2} state_t;
    localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd1} state_t;
`endif

    state_t      state_q, state_d;
    logic [3:0]  label_q, label_d;
    logic [31:0] data_q, data_d;
    logic [31:0] alu_res;
    logic        accept;

`ifdef RVCPU_EXU_MUL_EN
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [31:0] mul_lo;

    // Only the low word of the product is architecturally visible.
    assign mul_lo = opa_q * opb_q;
`else
    // Keeps the latency parameter referenced in the XOR build.
    logic unused_mul_cfg;
    assign unused_mul_cfg = ^MUL_CYCLES;
`endif

    // Single-cycle results are computed straight from the RS outputs at accept.
    always_comb begin
        alu_res = '0;
        case (opIn)
            OP_ADD: alu_res = dataIn1 + dataIn2;
            OP_SUB: alu_res = dataIn1 - dataIn2;
`ifdef RVCPU_EXU_MUL_EN
            OP_MUL: alu_res = '0;
`else
            OP_MUL: alu_res = dataIn1 ^ dataIn2;
`endif
            OP_SLT: alu_res = {31'd0, $signed(dataIn1) < $signed(dataIn2)};
            default: alu_res = '0;
        endcase
    end

    // In the grant cycle the broadcast entry is still Busy in the RS, so a
    // matching label must not be dispatched a second time.
    assign EXEable = (state_q == IDLE) ||
                     ((state_q == DONE) && cdbGrant && (labelIn != label_q));
    assign accept  = InEn && EXEable;

    always_comb begin
        state_d = state_q;
        label_d = label_q;
        data_d  = data_q;
`ifdef RVCPU_EXU_MUL_EN
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
`endif
        case (state_q)
            IDLE: ;
            DONE: if (cdbGrant) state_d = IDLE;
`ifdef RVCPU_EXU_MUL_EN
            EXEC: begin
                if (cnt_q == 4'd0) begin
                    state_d = DONE;
                    data_d  = mul_lo;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // A back-to-back accept in the grant cycle overrides the return to IDLE.
        if (accept) begin
            label_d = labelIn;
`ifdef RVCPU_EXU_MUL_EN
            if (opIn == OP_MUL) begin
                state_d = EXEC;
                cnt_d   = MUL_LAST;
                opa_d   = dataIn1;
                opb_d   = dataIn2;
            end else begin
                state_d = DONE;
                data_d  = alu_res;
            end
`else
            state_d = DONE;
            data_d  = alu_res;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q <= IDLE;
            label_q <= 4'h0;
            data_q  <= 32'h0;
`ifdef RVCPU_EXU_MUL_EN
            cnt_q   <= 4'd0;
            opa_q   <= 32'h0;
            opb_q   <= 32'h0;
`endif
        end else begin
            state_q <= state_d;
            label_q <= label_d;
            data_q  <= data_d;
`ifdef RVCPU_EXU_MUL_EN
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
`endif
        end
    end

    assign cdbReq   = (state_q == DONE);
    assign cdbLabel = label_q;
    assign cdbData  = data_q;

endmodule

// File: tb/tb_exec_unit_cdb.sv
// tb/tb_exec_unit_cdb.sv - directed self-checking bench for exec_unit_cdb

module tb_exec_unit_cdb;

    logic        clk;
    logic        RST;
    logic        InEn;
    logic [1:0]  opIn;
    logic [31:0] dataIn1;
    logic [31:0] dataIn2;
    logic [3:0]  labelIn;
    logic        EXEable;
    logic        cdbReq;
    logic        cdbGrant;
    logic [3:0]  cdbLabel;
    logic [31:0] cdbData;

    int pass_cnt  = 0;
    int total_cnt = 0;

    exec_unit_cdb #(.MUL_CYCLES(4)) dut (
        .clk      (clk),
        .RST      (RST),
        .InEn     (InEn),
        .opIn     (opIn),
        .dataIn1  (dataIn1),
        .dataIn2  (dataIn2),
        .labelIn  (labelIn),
        .EXEable  (EXEable),
        .cdbReq   (cdbReq),
        .cdbGrant (cdbGrant),
        .cdbLabel (cdbLabel),
        .cdbData  (cdbData)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_single(input logic [1:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [3:0] lbl);
        InEn = 1'b1; opIn = op; dataIn1 = a; dataIn2 = b; labelIn = lbl;
        step();
        InEn = 1'b0;
        dataIn1 = 32'hDEAD_BEEF; dataIn2 = 32'h1234_5678;
    endtask

    task automatic test_reset();
        RST = 1'b1;
        step();
        step();
        RST = 1'b0;
        #1;
        total_cnt++; if (cdbReq !== 1'b0) $display("FAIL reset_req got %b want 0", cdbReq); else pass_cnt++;
        total_cnt++; if (cdbLabel !== 4'h0) $display("FAIL reset_label got %h want 0", cdbLabel); else pass_cnt++;
        total_cnt++; if (cdbData !== 32'h0) $display("FAIL reset_data got %h want 0", cdbData); else pass_cnt++;
        total_cnt++; if (EXEable !== 1'b1) $display("FAIL reset_exeable got %b want 1", EXEable); else pass_cnt++;
    endtask

    task automatic test_add();
        cdbGrant = 1'b1;
        do_single(2'b00, 32'd5, 32'd7, 4'h1);
        total_cnt++; if (cdbReq !== 1'b1) $display("FAIL add_req got %b want 1", cdbReq); else pass_cnt++;
        total_cnt++; if (cdbData !== 32'd12) $display("FAIL add_data got %h want %h", cdbData, 32'd12); else pass_cnt++;
        total_cnt++; if (cdbLabel !== 4'h1) $display("FAIL add_label got %h want 1", cdbLabel); else pass_cnt++;
        step();
        total_cnt++; if (cdbReq !== 1'b0) $display("FAIL add_idle_req got %b want 0", cdbReq); else pass_cnt++;
        total_cnt++; if (EXEable !== 1'b1) $display("FAIL add_idle_exeable got %b want 1", EXEable); else pass_cnt++;
    endtask

    task automatic test_sub_slt();
        cdbGrant = 1'b1;
        do_single(2'b01, 32'd0, 32'd1, 4'h2);
        total_cnt++; if (cdbData !== 32'hFFFF_FFFF) $display("FAIL sub_wrap got %h want ffffffff", cdbData); else pass_cnt++;
        step();
        do_single(2'b11, 32'hFFFF_FFFF, 32'd1, 4'h3);
        total_cnt++; if (cdbData !== 32'd1) $display("FAIL slt_neg got %h want 1", cdbData); else pass_cnt++;
        total_cnt++; if (cdbLabel !== 4'h3) $display("FAIL slt_label got %h want 3", cdbLabel); else pass_cnt++;
        step();
        do_single(2'b11, 32'd1, 32'hFFFF_FFFF, 4'h4);
        total_cnt++; if (cdbData !== 32'd0) $display("FAIL slt_pos got %h want 0", cdbData); else pass_cnt++;
        step();
        do_single(2'b00, 32'hFFFF_FFFF, 32'd2, 4'h5);
        total_cnt++; if (cdbData !== 32'd1) $display("FAIL add_wrap got %h want 1", cdbData); else pass_cnt++;
        step();
    endtask

    task automatic test_mul();
        cdbGrant = 1'b1;
        do_single(2'b10, 32'd3, 32'h8000_0001, 4'h4);
`ifdef RVCPU_EXU_MUL_EN
        for (int i = 0; i < 4; i++) begin
            total_cnt++; if (EXEable !== 1'b0) $display("FAIL mul_busy_exeable cyc%0d got %b want 0", i, EXEable); else pass_cnt++;
            total_cnt++; if (cdbReq !== 1'b0) $display("FAIL mul_busy_req cyc%0d got %b want 0", i, cdbReq); else pass_cnt++;
            step();
        end
        total_cnt++; if (cdbReq !== 1'b1) $display("FAIL mul_req got %b want 1", cdbReq); else pass_cnt++;
        total_cnt++; if (cdbData !== 32'h8000_0003) $display("FAIL mul_data got %h want 80000003", cdbData); else pass_cnt++;
        total_cnt++; if (cdbLabel !== 4'h4) $display("FAIL mul_label got %h want 4", cdbLabel); else pass_cnt++;
`else
        total_cnt++; if (cdbReq !== 1'b1) $display("FAIL xor_req got %b want 1", cdbReq); else pass_cnt++;
        total_cnt++; if (cdbData !== 32'h8000_0002) $display("FAIL xor_data got %h want 80000002", cdbData); else pass_cnt++;
`endif
        step();
        total_cnt++; if (cdbReq !== 1'b0) $display("FAIL mul_after_req got %b want 0", cdbReq); else pass_cnt++;
    endtask

    task automatic test_hold();
        cdbGrant = 1'b0;
        do_single(2'b00, 32'd100, 32'd23, 4'h5);
        for (int i = 0; i < 5; i++) begin
            InEn = 1'b1; opIn = 2'b01; labelIn = 4'h6;
            dataIn1 = 32'd1000 + 32'(i); dataIn2 = 32'd1;
            #1;
            total_cnt++; if (EXEable !== 1'b0) $display("FAIL hold_exeable cyc%0d got %b want 0", i, EXEable); else pass_cnt++;
            step();
            total_cnt++; if (cdbReq !== 1'b1) $display("FAIL hold_req cyc%0d got %b want 1", i, cdbReq); else pass_cnt++;
            total_cnt++; if (cdbLabel !== 4'h5) $display("FAIL hold_label cyc%0d got %h want 5", i, cdbLabel); else pass_cnt++;
            total_cnt++; if (cdbData !== 32'd123) $display("FAIL hold_data cyc%0d got %h want %h", i, cdbData, 32'd123); else pass_cnt++;
        end
        InEn = 1'b0;
        cdbGrant = 1'b1;
        #1;
        total_cnt++; if (EXEable !== 1'b1) $display("FAIL hold_grant_exeable got %b want 1", EXEable); else pass_cnt++;
        step();
        total_cnt++; if (cdbReq !== 1'b0) $display("FAIL hold_release_req got %b want 0", cdbReq); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        cdbGrant = 1'b1;
        InEn = 1'b1; opIn = 2'b00;
        for (int i = 0; i < 3; i++) begin
            labelIn = 4'(i); dataIn1 = 32'd10 * 32'(i + 1); dataIn2 = 32'(i + 1);
            #1;
            total_cnt++; if (EXEable !== 1'b1) $display("FAIL b2b_exeable cyc%0d got %b want 1", i, EXEable); else pass_cnt++;
            step();
            total_cnt++; if (cdbReq !== 1'b1) $display("FAIL b2b_req cyc%0d got %b want 1", i, cdbReq); else pass_cnt++;
            total_cnt++; if (cdbLabel !== 4'(i)) $display("FAIL b2b_label cyc%0d got %h want %h", i, cdbLabel, 4'(i)); else pass_cnt++;
            total_cnt++; if (cdbData !== 32'd11 * 32'(i + 1)) $display("FAIL b2b_data cyc%0d got %h want %h", i, cdbData, 32'd11 * 32'(i + 1)); else pass_cnt++;
        end
        // RS still presents the entry being broadcast
        labelIn = 4'h2; dataIn1 = 32'd30; dataIn2 = 32'd3;
        #1;
        total_cnt++; if (EXEable !== 1'b0) $display("FAIL b2b_dup_exeable got %b want 0", EXEable); else pass_cnt++;
        step();
        InEn = 1'b0;
        total_cnt++; if (cdbReq !== 1'b0) $display("FAIL b2b_dup_req got %b want 0", cdbReq); else pass_cnt++;
        step();
        total_cnt++; if (cdbReq !== 1'b0) $display("FAIL b2b_dup_late_req got %b want 0", cdbReq); else pass_cnt++;
    endtask

    task automatic test_reset_inflight();
`ifdef RVCPU_EXU_MUL_EN
        cdbGrant = 1'b0;
        do_single(2'b10, 32'd2, 32'd5, 4'h7);
        step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        #1;
        total_cnt++; if (cdbReq !== 1'b0) $display("FAIL rst_mul_req got %b want 0", cdbReq); else pass_cnt++;
        total_cnt++; if (cdbData !== 32'h0) $display("FAIL rst_mul_data got %h want 0", cdbData); else pass_cnt++;
        total_cnt++; if (EXEable !== 1'b1) $display("FAIL rst_mul_exeable got %b want 1", EXEable); else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            step();
            total_cnt++; if (cdbReq !== 1'b0) $display("FAIL rst_mul_stale cyc%0d got %b want 0", i, cdbReq); else pass_cnt++;
        end
`endif
        cdbGrant = 1'b0;
        do_single(2'b00, 32'd1, 32'd1, 4'h9);
        total_cnt++; if (cdbReq !== 1'b1) $display("FAIL rst_done_pre_req got %b want 1", cdbReq); else pass_cnt++;
        RST = 1'b1; cdbGrant = 1'b1; InEn = 1'b1; labelIn = 4'hA; opIn = 2'b00;
        step();
        RST = 1'b0; InEn = 1'b0; cdbGrant = 1'b0;
        #1;
        total_cnt++; if (cdbReq !== 1'b0) $display("FAIL rst_done_req got %b want 0", cdbReq); else pass_cnt++;
        total_cnt++; if (cdbLabel !== 4'h0) $display("FAIL rst_done_label got %h want 0", cdbLabel); else pass_cnt++;
        total_cnt++; if (cdbData !== 32'h0) $display("FAIL rst_done_data got %h want 0", cdbData); else pass_cnt++;
        RST = 1'b1; InEn = 1'b1; labelIn = 4'hB;
        step();
        RST = 1'b0; InEn = 1'b0;
        #1;
        total_cnt++; if (cdbReq !== 1'b0) $display("FAIL rst_accept_req got %b want 0", cdbReq); else pass_cnt++;
        step();
        total_cnt++; if (cdbReq !== 1'b0) $display("FAIL rst_accept_late_req got %b want 0", cdbReq); else pass_cnt++;
    endtask

    initial begin
        RST = 1'b1; InEn = 1'b0; opIn = 2'b00; dataIn1 = '0; dataIn2 = '0;
        labelIn = 4'h0; cdbGrant = 1'b0;
        test_reset();
        test_add();
        test_sub_slt();
        test_mul();
        test_hold();
        test_back_to_back();
        test_reset_inflight();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
